// File: rtl/fetch_pkg.sv
// Fetch unit shared definitions: FSM state encoding and
// parameter defaults for the fetch slice.
package fetch_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int PC_STEP_DEF  = 1;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch bundle: instruction memory request/response and the
// decode-side valid/ready handshake.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries
// with a synchronous flush used on redirects.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 2 * XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request FSM, fetch PC,
// credit check against the prefetch buffer, redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(PC_STEP_DEF),
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                   clk,
    input  logic                   clr,
    fetch_if.master                bus,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int OW = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic [2*XLEN-1:0] head;

    // The outstanding request already owns a slot.
    assign credit = (occupancy + OW'(state == ST_WAIT)) < OW'(DEPTH);

    assign issue = !redirect_valid && credit &&
                   (state == ST_IDLE ||
                    (state == ST_WAIT && bus.imem_valid));

    assign push = state == ST_WAIT && bus.imem_valid &&
                  !redirect_valid;

    assign bus.imem_req  = issue && !clr;
    assign bus.imem_addr = pc;
    assign bus.id_valid  = occupancy != '0 && !redirect_valid;
    assign pop           = bus.id_valid && bus.id_ready;
    assign bus.id_instr  = head[XLEN-1:0];
    assign bus.id_pc     = head[2*XLEN-1:XLEN];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (issue) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_valid)
                    state_nxt = issue ? ST_WAIT : ST_IDLE;
                else if (redirect_valid)
                    state_nxt = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (bus.imem_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc     <= pc + PC_STEP;
                req_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc, bus.imem_rdata}),
        .rdata (head),
        .count (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle vector table with an
// auto-responding memory, then manual-response corner cases.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic        c;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
        logic [2:0]  occ;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;

    logic        auto_mem;
    logic        man_valid;
    logic [31:0] man_rdata;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    int checks = 0;
    int errors = 0;

    vec_t vq[$];

    fetch_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .PC_STEP  (32'd1),
        .RESET_PC (32'd0)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // One-cycle memory returning word = address.
    always @(posedge clk) begin
        pend      <= bus.imem_req;
        pend_addr <= bus.imem_addr;
    end

    assign bus.imem_valid = auto_mem ? pend : man_valid;
    assign bus.imem_rdata = auto_mem ? pend_addr : man_rdata;

    function automatic vec_t mk(
        input logic c, input logic r, input logic rv,
        input logic [31:0] rpc, input logic q,
        input logic [31:0] a, input logic v,
        input logic [31:0] pc, input logic [2:0] o);
        vec_t t;
        t.c = c; t.rdy = r; t.rv = rv; t.rpc = rpc;
        t.req = q; t.addr = a; t.idv = v;
        t.idpc = pc; t.occ = o;
        return t;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h",
                     nm, row, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.id_ready   = 1'b1;
        auto_mem       = 1'b1;
        man_valid      = 1'b0;
        man_rdata      = '0;

        // Reset, streaming, redirect coincident with response+pop.
        vq.push_back(mk(1,1,0,0,     0,0,0,0,0));
        vq.push_back(mk(1,1,0,0,     0,0,0,0,0));
        vq.push_back(mk(0,1,0,0,     1,0,0,0,0));
        vq.push_back(mk(0,1,0,0,     1,1,0,0,0));
        vq.push_back(mk(0,1,0,0,     1,2,1,0,1));
        vq.push_back(mk(0,1,0,0,     1,3,1,1,1));
        vq.push_back(mk(0,1,0,0,     1,4,1,2,1));
        vq.push_back(mk(0,1,1,'h40,  0,5,0,3,1));
        vq.push_back(mk(0,1,0,0,     1,'h40,0,0,0));
        vq.push_back(mk(0,1,0,0,     1,'h41,0,0,0));
        vq.push_back(mk(0,1,0,0,     1,'h42,1,'h40,1));
        // Stall for 10 cycles, buffer saturates, then drains.
        vq.push_back(mk(1,0,0,0,     0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,     1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,     1,1,0,0,0));
        vq.push_back(mk(0,0,0,0,     1,2,1,0,1));
        vq.push_back(mk(0,0,0,0,     1,3,1,0,2));
        vq.push_back(mk(0,0,0,0,     0,4,1,0,3));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0,0,0,0, 0,4,1,0,4));
        vq.push_back(mk(0,1,0,0,     0,4,1,0,4));
        vq.push_back(mk(0,1,0,0,     1,4,1,1,3));
        vq.push_back(mk(0,1,0,0,     1,5,1,2,2));
        vq.push_back(mk(0,1,0,0,     1,6,1,3,2));
        vq.push_back(mk(0,1,0,0,     1,7,1,4,2));
        vq.push_back(mk(0,1,0,0,     1,8,1,5,2));
        // Redirect to the top of the address space, then wrap.
        vq.push_back(mk(0,1,1,'hFFFFFFFF, 0,9,0,6,2));
        vq.push_back(mk(0,1,0,0, 1,'hFFFFFFFF,0,0,0));
        vq.push_back(mk(0,1,0,0, 1,0,0,0,0));
        vq.push_back(mk(0,1,0,0, 1,1,1,'hFFFFFFFF,1));

        for (int i = 0; i < vq.size(); i++) begin
            clr            = vq[i].c;
            bus.id_ready   = vq[i].rdy;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            @(negedge clk);
            chk("imem_req", i, 32'(bus.imem_req), 32'(vq[i].req));
            chk("imem_addr", i, bus.imem_addr, vq[i].addr);
            chk("id_valid", i, 32'(bus.id_valid), 32'(vq[i].idv));
            chk("occupancy", i, 32'(occupancy), 32'(vq[i].occ));
            if (vq[i].occ != 3'd0) begin
                chk("id_pc", i, bus.id_pc, vq[i].idpc);
                chk("id_instr", i, bus.id_instr, vq[i].idpc);
            end
            nxt();
        end

        // Redirect while a request is outstanding: stale drop.
        auto_mem       = 1'b0;
        redirect_valid = 1'b0;
        bus.id_ready   = 1'b1;
        clr            = 1'b1;
        nxt();
        clr = 1'b0;
        @(negedge clk);
        chk("h_req", 101, 32'(bus.imem_req), 32'd1);
        chk("h_addr", 101, bus.imem_addr, 32'd0);
        nxt();
        @(negedge clk);
        chk("h_req_wait", 102, 32'(bus.imem_req), 32'd0);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        chk("h_req_rd", 103, 32'(bus.imem_req), 32'd0);
        chk("h_idv_rd", 103, 32'(bus.id_valid), 32'd0);
        nxt();
        redirect_valid = 1'b0;
        man_valid      = 1'b1;
        man_rdata      = 32'hDEAD0000;
        @(negedge clk);
        chk("h_req_disc", 104, 32'(bus.imem_req), 32'd0);
        chk("h_occ_disc", 104, 32'(occupancy), 32'd0);
        nxt();
        man_valid = 1'b0;
        @(negedge clk);
        chk("h_occ_drop", 105, 32'(occupancy), 32'd0);
        chk("h_req_re", 105, 32'(bus.imem_req), 32'd1);
        chk("h_addr_re", 105, bus.imem_addr, 32'h40);
        nxt();
        man_valid = 1'b1;
        man_rdata = 32'h12345678;
        @(negedge clk);
        chk("h_req_b2b", 106, 32'(bus.imem_req), 32'd1);
        chk("h_addr_b2b", 106, bus.imem_addr, 32'h41);
        nxt();
        man_valid = 1'b0;
        @(negedge clk);
        chk("h_idv", 107, 32'(bus.id_valid), 32'd1);
        chk("h_idpc", 107, bus.id_pc, 32'h40);
        chk("h_instr", 107, bus.id_instr, 32'h12345678);
        chk("h_occ", 107, 32'(occupancy), 32'd1);
        chk("h_req_w", 107, 32'(bus.imem_req), 32'd0);
        nxt();

        // Reset mid-request, late response must be ignored.
        clr = 1'b1;
        @(negedge clk);
        chk("r_req", 108, 32'(bus.imem_req), 32'd0);
        chk("r_occ", 108, 32'(occupancy), 32'd0);
        chk("r_idv", 108, 32'(bus.id_valid), 32'd0);
        chk("r_addr", 108, bus.imem_addr, 32'd0);
        nxt();
        clr       = 1'b0;
        man_valid = 1'b1;
        man_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("r_req1", 109, 32'(bus.imem_req), 32'd1);
        chk("r_addr1", 109, bus.imem_addr, 32'd0);
        chk("r_occ1", 109, 32'(occupancy), 32'd0);
        nxt();
        man_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("r_addr2", 110, bus.imem_addr, 32'd1);
        chk("r_occ2", 110, 32'(occupancy), 32'd0);
        nxt();
        man_valid = 1'b0;
        @(negedge clk);
        chk("r_occ3", 111, 32'(occupancy), 32'd1);
        chk("r_idpc", 111, bus.id_pc, 32'd0);
        chk("r_instr", 111, bus.id_instr, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
